// File: rtl/train_epoch_scheduler.sv
// train_epoch_scheduler: epoch/sample sequencer for the perceptron training datapath.
// Define TRAIN_ABORT_EN to add an abort input that ends training early.
module train_epoch_scheduler #(
    parameter int NSAMPLES  = 201,
    parameter int ADDR_W    = 8,
    parameter int MAX_EPOCH = 16,
    parameter int EPOCH_W   = 5
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               start,
    input  logic               TtoY_Flag,
`ifdef TRAIN_ABORT_EN
    input  logic               abort,
`endif
    output logic [ADDR_W-1:0]  addr,
    output logic               enx1,
    output logic               enx2,
    output logic               ent,
    output logic               eny,
    output logic               enw1,
    output logic               enw2,
    output logic               enb,
    output logic [1:0]         Select,
    output logic [1:0]         Dselect,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic [EPOCH_W-1:0] epoch,
    output logic [ADDR_W-1:0]  err_count
);
    typedef enum logic [3:0] {
        IDLE, LOAD, EVAL, CHECK, UPD_W1, UPD_W2, UPD_B, NEXT, EPOCH_END, DONE
    } state_t;
    state_t state;
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state     <= IDLE;
            addr      <= '0;
            epoch     <= '0;
            err_count <= '0;
            converged <= 1'b0;
        end else
`ifdef TRAIN_ABORT_EN
        // abort freezes the counters and reports an unconverged finish
        if (abort && state != IDLE && state != DONE) begin
            state     <= DONE;
            converged <= 1'b0;
        end else
`endif
        begin
            case (state)
                IDLE: if (start) begin
                    state     <= LOAD;
                    addr      <= '0;
                    epoch     <= '0;
                    err_count <= '0;
                    converged <= 1'b0;
                end
                LOAD:   state <= EVAL;
                EVAL:   state <= CHECK;
                CHECK: if (TtoY_Flag) state <= NEXT;
                else begin
                    state     <= UPD_W1;
                    err_count <= &err_count ? err_count : err_count + ADDR_W'(1);
                end
                UPD_W1: state <= UPD_W2;
                UPD_W2: state <= UPD_B;
                UPD_B:  state <= NEXT;
                NEXT: if (addr == ADDR_W'(NSAMPLES - 1)) state <= EPOCH_END;
                else begin
                    addr  <= addr + ADDR_W'(1);
                    state <= LOAD;
                end
                EPOCH_END: if (err_count == '0) begin
                    converged <= 1'b1;
                    state     <= DONE;
                end else if (epoch == EPOCH_W'(MAX_EPOCH - 1)) state <= DONE;
                else begin
                    epoch     <= epoch + EPOCH_W'(1);
                    addr      <= '0;
                    err_count <= '0;
                    state     <= LOAD;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    always_comb begin
        enx1    = state == LOAD;
        enx2    = state == LOAD;
        ent     = state == LOAD;
        eny     = state == EVAL;
        enw1    = state == UPD_W1;
        enw2    = state == UPD_W2;
        enb     = state == UPD_B;
        busy    = state != IDLE;
        done    = state == DONE;
        Select  = state == UPD_W1 ? 2'b00 : state == UPD_W2 ? 2'b01 : state == UPD_B ? 2'b10 : 2'b11;
        Dselect = Select;
    end
endmodule

// File: tb/tb_train_epoch_scheduler.sv
// tb_train_epoch_scheduler: directed checks of the epoch scheduler with a
// scoreboard of expected end-of-training results.
module tb_train_epoch_scheduler;
    localparam int AW = 8;
    localparam int EW = 2;
    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          start = 1'b0;
    logic          TtoY_Flag;
    logic          abort = 1'b0;
    logic [AW-1:0] addr, err_count;
    logic [EW-1:0] epoch;
    logic          enx1, enx2, ent, eny, enw1, enw2, enb, busy, done, converged;
    logic [1:0]    Select, Dselect;
    int            checks = 0;
    int            errs = 0;
    int            mode = 0;
    int            n_w1 = 0, n_w2 = 0, n_b = 0;
    typedef struct {
        logic          conv;
        logic [EW-1:0] ep;
        logic [AW-1:0] err;
        logic [AW-1:0] ad;
    } exp_t;
    exp_t sb[$];

    train_epoch_scheduler #(.NSAMPLES(4), .ADDR_W(AW), .MAX_EPOCH(3), .EPOCH_W(EW)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .TtoY_Flag(TtoY_Flag),
`ifdef TRAIN_ABORT_EN
        .abort(abort),
`endif
        .addr(addr), .enx1(enx1), .enx2(enx2), .ent(ent), .eny(eny),
        .enw1(enw1), .enw2(enw2), .enb(enb), .Select(Select), .Dselect(Dselect),
        .busy(busy), .done(done), .converged(converged), .epoch(epoch), .err_count(err_count)
    );

    always #5 Clk = ~Clk;

    // mode 0: always correct, 1: always wrong, 2: wrong only at epoch 0 addr 2
    always_comb TtoY_Flag = mode == 0 ? 1'b1 : mode == 1 ? 1'b0 : !(epoch == 0 && addr == 2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        if (enw1) begin n_w1++; chk("sel_w1", {Select, Dselect}, 4'b0000); end
        if (enw2) begin n_w2++; chk("sel_w2", {Select, Dselect}, 4'b0101); end
        if (enb)  begin n_b++;  chk("sel_b",  {Select, Dselect}, 4'b1010); end
    end

    task automatic launch(input int m, input logic c, input int e, input int er, input int a);
        exp_t x;
        x.conv = c; x.ep = EW'(e); x.err = AW'(er); x.ad = AW'(a);
        sb.push_back(x);
        mode = m;
        n_w1 = 0; n_w2 = 0; n_b = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        exp_t x;
        n = 0;
        while (!done && n < budget) begin tick(); n++; end
        if (!done) chk("done_timeout", 0, 1);
        else if (sb.size() == 0) chk("sb_underflow", 0, 1);
        else begin
            x = sb.pop_front();
            chk("converged", converged, x.conv);
            chk("epoch", epoch, x.ep);
            chk("err_count", err_count, x.err);
            chk("addr", addr, x.ad);
        end
        tick();
        chk("idle_after_done", {busy, done}, 2'b00);
    endtask

    initial begin
        int n;
        Rst = 1'b0;
        tick(); tick();
        chk("rst_addr", addr, 0);
        chk("rst_epoch", epoch, 0);
        chk("rst_err", err_count, 0);
        chk("rst_busy_done_conv", {busy, done, converged}, 3'b000);
        chk("rst_enables", {enx1, enx2, ent, eny, enw1, enw2, enb}, 7'b0);
        chk("rst_sel", {Select, Dselect}, 4'b1111);
        Rst = 1'b1;
        tick();
        chk("idle_hold", busy, 0);

        launch(0, 1'b1, 0, 0, 3);
        chk("load_first", {enx1, enx2, ent, addr}, {3'b111, 8'd0});
        wait_done(200, n);
        chk("clean_latency", n, 17);
        chk("clean_no_upd", n_w1 + n_w2 + n_b, 0);

        launch(1, 1'b0, 2, 4, 3);
        wait_done(400, n);
        chk("dirty_latency", n, 87);
        chk("dirty_w1_cnt", n_w1, 12);
        chk("dirty_w2_cnt", n_w2, 12);
        chk("dirty_b_cnt", n_b, 12);

        launch(2, 1'b1, 1, 0, 3);
        wait_done(400, n);
        chk("one_err_latency", n, 37);
        chk("one_err_upd", {n_w1, n_w2, n_b}, {32'd1, 32'd1, 32'd1});

        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!enw2 && n < 50) begin tick(); n++; end
        chk("reach_upd_w2", enw2, 1);
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        chk("abort_rst_idle", {busy, enw2, enw1, enb}, 4'b0000);
        chk("abort_rst_addr", addr, 0);
        chk("abort_rst_sel", Select, 2'b11);
        tick();
        chk("stays_idle", busy, 0);
        launch(0, 1'b1, 0, 0, 3);
        chk("restart_addr_epoch", {addr, 6'd0, epoch}, 16'd0);
        wait_done(200, n);
        chk("restart_latency", n, 17);

        launch(0, 1'b1, 0, 0, 3);
        repeat (4) tick();
        chk("pre_start_addr", addr, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_addr", addr, 1);
        chk("busy_start_epoch", epoch, 0);
        chk("busy_start_state", {busy, eny}, 2'b11);
        wait_done(200, n);
        chk("busy_start_latency", n, 12);
`ifdef TRAIN_ABORT_EN
        launch(0, 1'b0, 0, 0, 1);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done_now", done, 1);
        wait_done(5, n);
        chk("abort_latency", n, 0);
`endif
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
